change_dispenser: RTL and testbench
===================================

# change_dispenser

Parametrised change-return engine for the vending machine datapath, replacing the fixed three-coin dispenser. On a start pulse it latches the amount due and greedily issues coins one at a time, largest fitting denomination first, over a valid/ready handshake to the coin mechanism. It reports completion and any undispensable remainder. Optionally, it tracks per-denomination coin inventory so that empty tubes are skipped.

## Interface
- `BAL_W`, 31: width of amounts, matching the machine's total-balance width.
- `NUM_COINS`, 3: number of denominations.
- `COIN_VALUES`, {1000,500,100}: packed `NUM_COINS*BAL_W` vector; slice i holds the value of coin i. Values ascend with index and are non-zero.
- `INV_W`, 8: inventory counter width (`INVENTORY_EN` only).
- `INIT_COUNT`, 10: inventory reset value per coin (`INVENTORY_EN` only).
- `clk` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `i_start` input 1: one-cycle request; sampled only in IDLE.
- `i_amount` input `BAL_W`: amount due, sampled with `i_start`.
- `o_busy` output 1: high in every state except IDLE.
- `o_coin` output `NUM_COINS`: one-hot coin being issued; zero when `o_coin_valid` is low.
- `o_coin_valid` output 1: coin offer to the mechanism.
- `i_coin_ready` input 1: the mechanism accepts the offered coin.
- `o_done` output 1: one-cycle pulse at the end of every accepted request.
- `o_remainder` output `BAL_W`: amount not dispensed; valid with `o_done` and held until the next start.
- `o_short` output 1: equals (`o_remainder` != 0), held like `o_remainder`.
- `i_refill` input `NUM_COINS`: add one coin of each set bit (`INVENTORY_EN` only).

## Operation
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE: when `i_start` is high, latch `due` <= `i_amount` and go to SELECT. While busy, `i_start` is ignored and no request is queued.
- SELECT: pick the highest index i with `COIN_VALUES[i]` <= `due` (and `count[i]` > 0 when `INVENTORY_EN` is defined).
  - If a coin is found: register the one-hot selection and go to ISSUE.
  - If none is found (including `due` == 0): set `o_remainder` <= `due` and go to DONE.
- ISSUE: hold `o_coin_valid` = 1 and keep `o_coin` stable until `i_coin_ready`.
  - On the handshake: `due` <= `due` - value, decrement `count[i]`, and go to SELECT.
- DONE: assert `o_done` for one cycle, then go to IDLE.
- Arithmetic: all subtractions are `BAL_W` wide. Underflow cannot occur because the value is never larger than `due`.
- Reset, including mid-operation: state IDLE, `due` = 0, `o_coin` = 0, `o_coin_valid` = 0, `o_busy` = 0, `o_done` = 0, `o_remainder` = 0, `o_short` = 0, every `count` = `INIT_COUNT`. A coin on offer at reset is withdrawn and not counted.

## Timing
- `i_start` at cycle 0 gives SELECT at cycle 1 and the first `o_coin_valid` at cycle 2.
- With `i_coin_ready` held high, each coin costs 2 cycles (ISSUE, SELECT).
- `o_done` follows the final SELECT by 1 cycle. A zero-coin request returns `o_done` at cycle 2.
- `o_busy` goes low in the cycle after DONE. A new `i_start` is accepted in that same cycle.
- Under backpressure, `o_coin_valid` and `o_coin` are unchanged every cycle until the handshake.

## Configuration
- `CHANGE_DISPENSER_INVENTORY_EN` defined:
  - Per-coin `INV_W` counters exist. SELECT skips empty coins.
  - `i_refill` increments counters and saturates at all-ones.
  - A refill and a handshake decrement of the same coin in the same cycle leave the count unchanged.
- `CHANGE_DISPENSER_INVENTORY_EN` undefined:
  - Counters, `INV_W`, `INIT_COUNT` and `i_refill` are removed.
  - Supply is unlimited, so `o_short` is set only when `due` is not a sum of available denominations.

## Structure
- Shared package/include (extends the machine's definitions file):
  - state encoding localparams
  - default `COIN_VALUES` and the coin-count constant, kept consistent with the machine's existing coin definitions
- Sub-module `coin_selector`: combinational priority pick.
  - Inputs: `due`, `COIN_VALUES` and the availability mask.
  - Outputs: one-hot selection, selected value and a found flag.
  - This isolates the `NUM_COINS`-wide compare/priority logic from the FSM.

## Test plan
- `i_amount`=1700, ready tied high: coins 1000, 500, 100, 100 in that order, one handshake each; `o_done` with `o_remainder`=0, `o_short`=0.
- `i_amount`=50: no `o_coin_valid`; `o_done` at cycle 2 with `o_remainder`=50, `o_short`=1.
- `i_amount`=600, `i_coin_ready` low for 3 cycles on the first coin: `o_coin`=3'b010 held stable for 3 cycles; the second coin is 3'b001 only after acceptance.
- `INVENTORY_EN`, `count[2]` driven to 0: `i_amount`=1000 issues 500 then 500. Then `i_refill`=3'b100 restores `count[2]` to 1.
- `reset_n` low while ISSUE holds coin 1000: all outputs 0 asynchronously, counts back to `INIT_COUNT`; the next `i_start` (`i_amount`=100) dispenses normally.
- `i_start` pulsed while busy with 1500: ignored; exactly 2 coins are issued and one `o_done`.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared coin definitions and FSM state encoding for the change dispenser.
// The default coin set mirrors the machine's existing three-coin dispenser.
package change_dispenser_pkg;

   localparam int CD_BAL_W     = 31;
   localparam int CD_NUM_COINS = 3;

   // Slice i holds the value of coin i, ascending with index.
   localparam logic [CD_NUM_COINS*CD_BAL_W-1:0] CD_COIN_VALUES =
      {31'd1000, 31'd500, 31'd100};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Combinational priority pick: highest-index available coin whose value fits in due.
// Zero latency; no handshake.
module coin_selector
   import change_dispenser_pkg::*;
#(
   parameter int                           BAL_W       = CD_BAL_W,
   parameter int                           NUM_COINS   = CD_NUM_COINS,
   parameter logic [NUM_COINS*BAL_W-1:0]   COIN_VALUES = CD_COIN_VALUES
) (
   input  logic [BAL_W-1:0]     i_due,
   input  logic [NUM_COINS-1:0] i_avail,
   output logic [NUM_COINS-1:0] o_sel,
   output logic [BAL_W-1:0]     o_value,
   output logic                 o_found
);

   always_comb begin
      o_sel   = '0;
      o_value = '0;
      o_found = 1'b0;
      // Later (higher-index, larger) matches override earlier ones.
      for (int i = 0; i < NUM_COINS; i++) begin
         if (i_avail[i] && (COIN_VALUES[i*BAL_W +: BAL_W] <= i_due)) begin
            o_sel    = '0;
            o_sel[i] = 1'b1;
            o_value  = COIN_VALUES[i*BAL_W +: BAL_W];
            o_found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: first coin offered 2 cycles after start, 2 cycles per coin, done pulse after last select.
// Coin offer held stable until i_coin_ready; optional tube inventory via CHANGE_DISPENSER_INVENTORY_EN.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int                           BAL_W       = CD_BAL_W,
   parameter int                           NUM_COINS   = CD_NUM_COINS,
   parameter logic [NUM_COINS*BAL_W-1:0]   COIN_VALUES = CD_COIN_VALUES
`ifdef CHANGE_DISPENSER_INVENTORY_EN
   ,
   parameter int                           INV_W       = 8,
   parameter int                           INIT_COUNT  = 10
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic [BAL_W-1:0]     i_amount,
   output logic                 o_busy,
   output logic [NUM_COINS-1:0] o_coin,
   output logic                 o_coin_valid,
   input  logic                 i_coin_ready,
   output logic                 o_done,
   output logic [BAL_W-1:0]     o_remainder,
   output logic                 o_short
`ifdef CHANGE_DISPENSER_INVENTORY_EN
   ,
   input  logic [NUM_COINS-1:0] i_refill
`endif
);

   state_t               r_state;
   logic [BAL_W-1:0]     r_due;
   logic [BAL_W-1:0]     r_value;

   logic [NUM_COINS-1:0] w_avail;
   logic [NUM_COINS-1:0] w_sel;
   logic [BAL_W-1:0]     w_value;
   logic                 w_found;
   logic                 w_handshake;

   assign w_handshake = (r_state == ST_ISSUE) && i_coin_ready;

`ifdef CHANGE_DISPENSER_INVENTORY_EN
   logic [INV_W-1:0] r_count [NUM_COINS];

   for (genvar g = 0; g < NUM_COINS; g++) begin : g_inv
      logic w_dec;
      logic w_inc;
      assign w_dec      = w_handshake && o_coin[g];
      assign w_inc      = i_refill[g] && (r_count[g] != {INV_W{1'b1}});
      assign w_avail[g] = (r_count[g] != '0);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_count[g] <= INV_W'(INIT_COUNT);
         end else if (w_dec && i_refill[g]) begin
            // Refill and dispense of the same coin cancel out.
            r_count[g] <= r_count[g];
         end else if (w_dec) begin
            r_count[g] <= r_count[g] - 1'b1;
         end else if (w_inc) begin
            r_count[g] <= r_count[g] + 1'b1;
         end
      end
   end
`else
   assign w_avail = '1;
`endif

   coin_selector #(
      .BAL_W       (BAL_W),
      .NUM_COINS   (NUM_COINS),
      .COIN_VALUES (COIN_VALUES)
   ) u_coin_selector (
      .i_due   (r_due),
      .i_avail (w_avail),
      .o_sel   (w_sel),
      .o_value (w_value),
      .o_found (w_found)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_due        <= '0;
         r_value      <= '0;
         o_busy       <= 1'b0;
         o_coin       <= '0;
         o_coin_valid <= 1'b0;
         o_done       <= 1'b0;
         o_remainder  <= '0;
         o_short      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_due   <= i_amount;
                  o_busy  <= 1'b1;
                  r_state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_found) begin
                  o_coin       <= w_sel;
                  r_value      <= w_value;
                  o_coin_valid <= 1'b1;
                  r_state      <= ST_ISSUE;
               end else begin
                  o_remainder <= r_due;
                  o_short     <= (r_due != '0);
                  o_done      <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_ISSUE: begin
               if (i_coin_ready) begin
                  r_due        <= r_due - r_value;
                  o_coin       <= '0;
                  o_coin_valid <= 1'b0;
                  r_state      <= ST_SELECT;
               end
            end
            ST_DONE: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;
   import change_dispenser_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_start;
   logic [30:0] i_amount;
   logic        o_busy;
   logic [2:0]  o_coin;
   logic        o_coin_valid;
   logic        i_coin_ready;
   logic        o_done;
   logic [30:0] o_remainder;
   logic        o_short;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
   logic [2:0]  i_refill;
`endif

   int checks = 0;
   int errors = 0;

   logic [2:0]  coins[$];
   int          ndone;
   int          done_cyc;
   int          first_vld;
   int          cyc;
   logic [30:0] rem_at_done;
   logic        short_at_done;

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (i_start),
      .i_amount     (i_amount),
      .o_busy       (o_busy),
      .o_coin       (o_coin),
      .o_coin_valid (o_coin_valid),
      .i_coin_ready (i_coin_ready),
      .o_done       (o_done),
      .o_remainder  (o_remainder),
      .o_short      (o_short)
`ifdef CHANGE_DISPENSER_INVENTORY_EN
      ,
      .i_refill     (i_refill)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; that cycle holds i_start and counts as cycle 0.
   task automatic start(input logic [30:0] amt);
      i_start   = 1'b1;
      i_amount  = amt;
      coins.delete();
      ndone     = 0;
      done_cyc  = -1;
      first_vld = -1;
      cyc       = 0;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         if (o_coin_valid && first_vld < 0) first_vld = cyc;
         if (o_coin_valid && i_coin_ready) coins.push_back(o_coin);
         if (o_done) begin
            ndone++;
            done_cyc      = cyc;
            rem_at_done   = o_remainder;
            short_at_done = o_short;
         end
         i_start = 1'b0;
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      i_start      = 1'b0;
      i_amount     = '0;
      i_coin_ready = 1'b1;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
      i_refill     = '0;
`endif
      #3;
      chk("rst_busy",  32'(o_busy), 0);
      chk("rst_valid", 32'(o_coin_valid), 0);
      chk("rst_coin",  32'(o_coin), 0);
      chk("rst_done",  32'(o_done), 0);
      chk("rst_rem",   32'(o_remainder), 0);
      chk("rst_short", 32'(o_short), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // 1700 with ready high: 1000, 500, 100, 100
      start(1700);
      run_cycles(12);
      chk("t1_first_vld", first_vld, 2);
      chk("t1_ncoins", coins.size(), 4);
      if (coins.size() == 4) begin
         chk("t1_coin0", 32'(coins[0]), 32'b100);
         chk("t1_coin1", 32'(coins[1]), 32'b010);
         chk("t1_coin2", 32'(coins[2]), 32'b001);
         chk("t1_coin3", 32'(coins[3]), 32'b001);
      end
      chk("t1_ndone", ndone, 1);
      chk("t1_done_cyc", done_cyc, 10);
      chk("t1_rem", 32'(rem_at_done), 0);
      chk("t1_short", 32'(short_at_done), 0);
      chk("t1_idle_busy", 32'(o_busy), 0);

      // 50: nothing fits
      start(50);
      run_cycles(4);
      chk("t2_first_vld", first_vld, -1);
      chk("t2_done_cyc", done_cyc, 2);
      chk("t2_rem", 32'(rem_at_done), 50);
      chk("t2_short", 32'(short_at_done), 1);
      chk("t2_rem_held", 32'(o_remainder), 50);
      chk("t2_short_held", 32'(o_short), 1);

      // 600 with 3 stalled cycles on the first coin
      i_coin_ready = 1'b0;
      start(600);
      run_cycles(2);
      chk("t3_vld_c2", 32'(o_coin_valid), 1);
      chk("t3_coin_c2", 32'(o_coin), 32'b010);
      run_cycles(1);
      chk("t3_coin_c3", 32'(o_coin), 32'b010);
      run_cycles(1);
      chk("t3_coin_c4", 32'(o_coin), 32'b010);
      chk("t3_vld_c4", 32'(o_coin_valid), 1);
      i_coin_ready = 1'b1;
      run_cycles(1);
      chk("t3_vld_c5", 32'(o_coin_valid), 0);
      chk("t3_coin_c5", 32'(o_coin), 0);
      run_cycles(5);
      chk("t3_ncoins", coins.size(), 1);
      if (coins.size() == 1) chk("t3_coin_second", 32'(coins[0]), 32'b001);
      chk("t3_done_cyc", done_cyc, 8);
      chk("t3_rem", 32'(rem_at_done), 0);

      // reset while coin 1000 is on offer
      i_coin_ready = 1'b0;
      start(1000);
      run_cycles(2);
      chk("t4_pre_coin", 32'(o_coin), 32'b100);
      #2 reset_n = 1'b0;
      #1;
      chk("t4_rst_valid", 32'(o_coin_valid), 0);
      chk("t4_rst_coin", 32'(o_coin), 0);
      chk("t4_rst_busy", 32'(o_busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      i_coin_ready = 1'b1;
      @(negedge clk);
      start(100);
      run_cycles(6);
      chk("t4_ncoins", coins.size(), 1);
      if (coins.size() == 1) chk("t4_coin", 32'(coins[0]), 32'b001);
      chk("t4_done_cyc", done_cyc, 4);
      chk("t4_short", 32'(short_at_done), 0);

      // start pulses while busy with 1500 are ignored
      start(1500);
      run_cycles(1);
      i_start = 1'b1; i_amount = 100;
      run_cycles(2);
      i_start = 1'b1; i_amount = 500;
      run_cycles(9);
      chk("t5_ncoins", coins.size(), 2);
      if (coins.size() == 2) begin
         chk("t5_coin0", 32'(coins[0]), 32'b100);
         chk("t5_coin1", 32'(coins[1]), 32'b010);
      end
      chk("t5_ndone", ndone, 1);
      chk("t5_done_cyc", done_cyc, 6);
      chk("t5_busy_end", 32'(o_busy), 0);

`ifdef CHANGE_DISPENSER_INVENTORY_EN
      // drain coin 1000 tube, skip it, then refill one
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start(10000);
      run_cycles(24);
      chk("inv_drain_n", coins.size(), 10);
      chk("inv_drain_rem", 32'(rem_at_done), 0);
      start(1000);
      run_cycles(8);
      chk("inv_skip_n", coins.size(), 2);
      if (coins.size() == 2) begin
         chk("inv_skip0", 32'(coins[0]), 32'b010);
         chk("inv_skip1", 32'(coins[1]), 32'b010);
      end
      i_refill = 3'b100;
      @(negedge clk);
      i_refill = 3'b000;
      start(1000);
      run_cycles(6);
      chk("inv_refill_n", coins.size(), 1);
      if (coins.size() == 1) chk("inv_refill_coin", 32'(coins[0]), 32'b100);
      start(1000);
      run_cycles(8);
      chk("inv_empty_again", coins.size(), 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
